quad_decoder: RTL

//  Quadrature (A/B) decoder: turns two asynchronous encoder phases into step/direction

---
 rtl/quad_decoder.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/quad_decoder.sv
// quad_decoder: quadrature (A/B) encoder decoder.
//
// Synchronizes the two asynchronous encoder phases, decodes Gray-code
// transitions into step/dir events and keeps a WIDTH-bit modulo up/down
// position count with a synchronous load. Double transitions (both phases
// changing in one cycle) set a sticky error flag.
//
// Optional feature: define QDEC_FILTER_EN to add a per-phase glitch filter
// after the synchronizer (a phase change is accepted only after it holds
// FILT_LEN consecutive cycles).
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset
//   qa, qb   in   encoder phases, asynchronous
//   set      in   load position from a
//   a        in   position load value
//   err_clr  in   clear sticky err
//   step     out  one-cycle pulse per legal transition
//   dir      out  direction of last step (1 = increment)
//   out      out  current position
//   err      out  sticky illegal-transition flag
//
// Decode control state:
//   state        | meaning
//   -------------+----------------------------------------------------
//   filling      | primed=0, fill counter running down; no step/err
//   primed       | prev holds last phase pair; every cycle is decoded

module quad_decoder #(
    parameter int WIDTH    = 8,
    parameter int FILT_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             qa,
    input  logic             qb,
    input  logic             set,
    input  logic [WIDTH-1:0] a,
    input  logic             err_clr,
    output logic             step,
    output logic             dir,
    output logic [WIDTH-1:0] out,
    output logic             err
);

    // Fill counter is sized for the longest (filtered) pipeline fill.
    localparam int FILL_W = $clog2(FILT_LEN + 3);
`ifdef QDEC_FILTER_EN
    localparam int FILL_LEN = 2 + FILT_LEN;
`else
    localparam int FILL_LEN = 2;
`endif
    localparam logic [FILL_W-1:0] FILL_LOAD = FILL_W'(FILL_LEN);

    // Two-flop synchronizers, index 1 = phase A, index 0 = phase B.
    logic [1:0] sync1_q, sync1_d;
    logic [1:0] sync2_q, sync2_d;
    logic [1:0] cur;

    assign sync1_d = {qa, qb};
    assign sync2_d = sync1_q;

`ifdef QDEC_FILTER_EN
    localparam int FW = $clog2(FILT_LEN) + 1;
    localparam logic [FW-1:0] FILT_LOAD = FW'(FILT_LEN - 1);

    logic [1:0]    flt_q, flt_d;
    logic [FW-1:0] flt_cnt_q [2];
    logic [FW-1:0] flt_cnt_d [2];

    // Down-counter per phase: restarts whenever the synced value matches the
    // filtered one, and the filtered value flips when it reaches zero.
    always_comb begin
        flt_d = flt_q;
        for (int i = 0; i < 2; i++) begin
            flt_cnt_d[i] = FILT_LOAD;
            if (sync2_q[i] != flt_q[i]) begin
                if (flt_cnt_q[i] == '0) begin
                    flt_d[i] = sync2_q[i];
                end else begin
                    flt_cnt_d[i] = flt_cnt_q[i] - FW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flt_q        <= '0;
            flt_cnt_q[0] <= FILT_LOAD;
            flt_cnt_q[1] <= FILT_LOAD;
        end else begin
            flt_q        <= flt_d;
            flt_cnt_q[0] <= flt_cnt_d[0];
            flt_cnt_q[1] <= flt_cnt_d[1];
        end
    end

    assign cur = flt_q;
`else
    assign cur = sync2_q;
`endif

    logic              primed_q, primed_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [1:0]        prev_q, prev_d;
    logic              step_q, step_d;
    logic              dir_q, dir_d;
    logic [WIDTH-1:0]  out_q, out_d;
    logic              err_q, err_d;

    always_comb begin
        primed_d = primed_q;
        fill_d   = fill_q;
        prev_d   = prev_q;
        step_d   = 1'b0;
        dir_d    = dir_q;
        out_d    = out_q;
        err_d    = err_q;

        if (err_clr) begin
            err_d = 1'b0;
        end

        if (!primed_q) begin
            if (fill_q == '0) begin
                primed_d = 1'b1;
                prev_d   = cur;
            end else begin
                fill_d = fill_q - FILL_W'(1);
            end
        end else begin
            prev_d = cur;
            case ({prev_q, cur})
                4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: begin
                    step_d = 1'b1;
                    dir_d  = 1'b1;
                    out_d  = out_q + WIDTH'(1);
                end
                4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: begin
                    step_d = 1'b1;
                    dir_d  = 1'b0;
                    out_d  = out_q - WIDTH'(1);
                end
                // Illegal double transition beats a same-cycle clear.
                4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: begin
                    err_d = 1'b1;
                end
                default: ;
            endcase
        end

        // Load discards any same-cycle count but leaves step/dir intact.
        if (set) begin
            out_d = a;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            primed_q <= 1'b0;
            fill_q   <= FILL_LOAD;
            prev_q   <= '0;
            step_q   <= 1'b0;
            dir_q    <= 1'b0;
            out_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            primed_q <= primed_d;
            fill_q   <= fill_d;
            prev_q   <= prev_d;
            step_q   <= step_d;
            dir_q    <= dir_d;
            out_q    <= out_d;
            err_q    <= err_d;
        end
    end

    assign step = step_q;
    assign dir  = dir_q;
    assign out  = out_q;
    assign err  = err_q;

endmodule
